mem_bus_arbiter: RTL and testbench

Two-master arbiter for the on-chip memory bus: shares the single master port of the memory bus switch between the BIU (master 0) and a second bus master (master 1, DMA/debug loader). Sits between the BIU memory-bus outputs and the memory bus switch's master inputs. Grants are round-robin per transaction, with an optional lock that lets master 1 hold the bus across a burst, and an optional watchdog that terminates unacknowledged cycles.

---
 rtl/mem_bus_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the on-chip memory bus (BIU = master 0, DMA/debug = master 1).
// Optional ack watchdog is built when MEM_ARB_WATCHDOG_EN is defined.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  // master 0 (BIU)
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  // master 1 (DMA / debug loader)
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  input  logic        m1_lock_i,
  // bus switch master port
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_bus_arbiter: TIMEOUT_CYCLES must be within 1..255");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   last_grant_q, last_grant_d;  // index of the master granted most recently
  logic   cur_stb;
  logic   wd_expire;

  // Strobe of whichever master currently owns the bus.
  always_comb begin
    unique case (state_q)
      GNT0:    cur_stb = m0_stb_i;
      GNT1:    cur_stb = m1_stb_i;
      default: cur_stb = 1'b0;
    endcase
  end

`ifdef MEM_ARB_WATCHDOG_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wd_cnt_q, wd_cnt_d;

  // Expiry fires on the TIMEOUT_CYCLES-th waiting cycle; a same-cycle ack wins.
  assign wd_expire = (state_q != IDLE) && cur_stb && !s_ack_i && (wd_cnt_q == WD_LAST);

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_q == IDLE || s_ack_i) begin
      wd_cnt_d = '0;
    end else if (cur_stb) begin
      wd_cnt_d = wd_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  assign wd_expire = 1'b0;
`endif

  // Next-state and last-grant logic.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (m0_stb_i && m1_stb_i) begin
          state_d = last_grant_q ? GNT0 : GNT1;
        end else if (m0_stb_i) begin
          state_d = GNT0;
        end else if (m1_stb_i) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (s_ack_i || !m0_stb_i || wd_expire) begin
          state_d      = IDLE;
          last_grant_d = 1'b0;
        end
      end
      GNT1: begin
        if (s_ack_i) begin
          state_d      = m1_lock_i ? GNT1 : IDLE;
          last_grant_d = 1'b1;
        end else if (!m1_stb_i || wd_expire) begin
          state_d      = IDLE;
          last_grant_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Bus multiplexer: the granted master drives the switch, everything else reads as zero.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    grant_o  = 2'b00;
    unique case (state_q)
      GNT0: begin
        grant_o  = 2'b01;
        s_cyc_o  = m0_stb_i && !wd_expire;
        s_stb_o  = m0_stb_i && !wd_expire;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = wd_expire;
      end
      GNT1: begin
        grant_o  = 2'b10;
        s_cyc_o  = m1_stb_i && !wd_expire;
        s_stb_o  = m1_stb_i && !wd_expire;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = wd_expire;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter; expectations follow MEM_ARB_WATCHDOG_EN if defined.
module tb_mem_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        m0_stb_i, m0_we_i, m1_stb_i, m1_we_i, m1_lock_i;
  logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_ack_i;
  logic [1:0]  grant_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .m0_stb_i (m0_stb_i),
    .m0_we_i  (m0_we_i),
    .m0_adr_i (m0_adr_i),
    .m0_dat_i (m0_dat_i),
    .m0_sel_i (m0_sel_i),
    .m0_dat_o (m0_dat_o),
    .m0_ack_o (m0_ack_o),
    .m0_err_o (m0_err_o),
    .m1_stb_i (m1_stb_i),
    .m1_we_i  (m1_we_i),
    .m1_adr_i (m1_adr_i),
    .m1_dat_i (m1_dat_i),
    .m1_sel_i (m1_sel_i),
    .m1_dat_o (m1_dat_o),
    .m1_ack_o (m1_ack_o),
    .m1_err_o (m1_err_o),
    .m1_lock_i(m1_lock_i),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_we_o   (s_we_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_sel_o  (s_sel_o),
    .s_dat_i  (s_dat_i),
    .s_ack_i  (s_ack_i),
    .grant_o  (grant_o)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clear_inputs();
    m0_stb_i = 1'b0; m0_we_i = 1'b0; m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0;
    m1_stb_i = 1'b0; m1_we_i = 1'b0; m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0;
    m1_lock_i = 1'b0; s_dat_i = '0; s_ack_i = 1'b0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst_n_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #3 rst_n_i = 1'b1;
  endtask

  // Start of a new cycle: just after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Safety net so the bench always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    // ---------------- reset state ----------------
    reset_dut();
    #1;
    check("rst_grant", 32'(grant_o), 32'h0);
    check("rst_s_stb", 32'(s_stb_o), 32'h0);
    check("rst_s_cyc", 32'(s_cyc_o), 32'h0);
    check("rst_m0_ack", 32'(m0_ack_o), 32'h0);
    check("rst_m1_err", 32'(m1_err_o), 32'h0);

    // ---------------- single master 0 read ----------------
    tick();
    m0_stb_i = 1'b1; m0_adr_i = 32'h0000_0010; m0_sel_i = 4'hF; m0_we_i = 1'b0;
    #2;
    check("rd_c0_grant", 32'(grant_o), 32'h0);
    check("rd_c0_stb", 32'(s_stb_o), 32'h0);
    tick();
    s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
    #2;
    check("rd_c1_grant", 32'(grant_o), 32'h1);
    check("rd_c1_stb", 32'(s_stb_o), 32'h1);
    check("rd_c1_adr", s_adr_o, 32'h0000_0010);
    check("rd_c1_sel", 32'(s_sel_o), 32'hF);
    check("rd_c1_ack", 32'(m0_ack_o), 32'h1);
    check("rd_c1_dat", m0_dat_o, 32'hDEAD_BEEF);
    check("rd_c1_m1_ack", 32'(m1_ack_o), 32'h0);
    check("rd_c1_m1_dat", m1_dat_o, 32'h0);
    tick();
    m0_stb_i = 1'b0; s_ack_i = 1'b0; s_dat_i = '0;
    #2;
    check("rd_c2_grant", 32'(grant_o), 32'h0);
    check("rd_c2_ack", 32'(m0_ack_o), 32'h0);

    // ---------------- both masters, round-robin ----------------
    reset_dut();
    tick();
    m0_stb_i = 1'b1; m0_adr_i = 32'hA000_0000; m0_we_i = 1'b1;
    m1_stb_i = 1'b1; m1_adr_i = 32'hB000_0000;
    #2;
    check("rr_c0_grant", 32'(grant_o), 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      s_ack_i = 1'b1;
      #2;
      check("rr_grant", 32'(grant_o), (i % 2 == 0) ? 32'h1 : 32'h2);
      check("rr_adr", s_adr_o, (i % 2 == 0) ? 32'hA000_0000 : 32'hB000_0000);
      check("rr_m0_ack", 32'(m0_ack_o), (i % 2 == 0) ? 32'h1 : 32'h0);
      check("rr_m1_ack", 32'(m1_ack_o), (i % 2 == 0) ? 32'h0 : 32'h1);
      tick();
      s_ack_i = 1'b0;
      #2;
      check("rr_idle_grant", 32'(grant_o), 32'h0);
    end
    m0_stb_i = 1'b0; m1_stb_i = 1'b0; m0_we_i = 1'b0;

    // ---------------- master 1 locked burst ----------------
    reset_dut();
    tick();
    m1_stb_i = 1'b1; m1_lock_i = 1'b1; m1_we_i = 1'b1; m1_dat_i = 32'h1111_0001;
    #2;
    check("lk_c0_grant", 32'(grant_o), 32'h0);
    tick();
    m0_stb_i = 1'b1; s_ack_i = 1'b1;
    #2;
    check("lk_c1_grant", 32'(grant_o), 32'h2);
    check("lk_c1_m1_ack", 32'(m1_ack_o), 32'h1);
    check("lk_c1_m0_ack", 32'(m0_ack_o), 32'h0);
    check("lk_c1_we", 32'(s_we_o), 32'h1);
    check("lk_c1_dat", s_dat_o, 32'h1111_0001);
    tick();
    m1_dat_i = 32'h1111_0002;
    #2;
    check("lk_c2_grant", 32'(grant_o), 32'h2);
    check("lk_c2_dat", s_dat_o, 32'h1111_0002);
    check("lk_c2_m1_ack", 32'(m1_ack_o), 32'h1);
    tick();
    m1_dat_i = 32'h1111_0003; m1_lock_i = 1'b0;
    #2;
    check("lk_c3_grant", 32'(grant_o), 32'h2);
    check("lk_c3_m1_ack", 32'(m1_ack_o), 32'h1);
    tick();
    m1_stb_i = 1'b0; m1_we_i = 1'b0; s_ack_i = 1'b0;
    #2;
    check("lk_c4_grant", 32'(grant_o), 32'h0);
    tick();
    s_ack_i = 1'b1;
    #2;
    check("lk_c5_grant", 32'(grant_o), 32'h1);
    check("lk_c5_m0_ack", 32'(m0_ack_o), 32'h1);
    tick();
    m0_stb_i = 1'b0; s_ack_i = 1'b0;
    #2;
    check("lk_c6_grant", 32'(grant_o), 32'h0);

    // ---------------- master 0 abort, master 1 pending ----------------
    reset_dut();
    tick();
    m0_stb_i = 1'b1; m0_adr_i = 32'h0000_0040;
    #2;
    check("ab_c0_grant", 32'(grant_o), 32'h0);
    tick();
    #2;
    check("ab_c1_grant", 32'(grant_o), 32'h1);
    check("ab_c1_stb", 32'(s_stb_o), 32'h1);
    tick();
    m0_stb_i = 1'b0; m1_stb_i = 1'b1; m1_adr_i = 32'h0000_0080; m1_sel_i = 4'h3;
    #2;
    check("ab_c2_grant", 32'(grant_o), 32'h1);
    check("ab_c2_stb", 32'(s_stb_o), 32'h0);
    check("ab_c2_cyc", 32'(s_cyc_o), 32'h0);
    check("ab_c2_m0_ack", 32'(m0_ack_o), 32'h0);
    tick();
    s_ack_i = 1'b1;
    #2;
    check("ab_c3_grant", 32'(grant_o), 32'h0);
    check("ab_c3_m0_ack", 32'(m0_ack_o), 32'h0);
    check("ab_c3_m1_ack", 32'(m1_ack_o), 32'h0);
    tick();
    s_ack_i = 1'b0;
    #2;
    check("ab_c4_grant", 32'(grant_o), 32'h2);
    check("ab_c4_adr", s_adr_o, 32'h0000_0080);
    check("ab_c4_sel", 32'(s_sel_o), 32'h3);
    tick();
    s_ack_i = 1'b1; s_dat_i = 32'h0000_1234;
    #2;
    check("ab_c5_m1_ack", 32'(m1_ack_o), 32'h1);
    check("ab_c5_m1_dat", m1_dat_o, 32'h0000_1234);
    check("ab_c5_m0_dat", m0_dat_o, 32'h0);
    tick();
    m1_stb_i = 1'b0; s_ack_i = 1'b0; s_dat_i = '0;
    #2;
    check("ab_c6_grant", 32'(grant_o), 32'h0);

    // ---------------- slave never acks ----------------
    reset_dut();
    tick();
    m0_stb_i = 1'b1;
    #2;
    for (int k = 1; k <= 3; k++) begin
      tick();
      #2;
      check("wd_wait_grant", 32'(grant_o), 32'h1);
      check("wd_wait_err", 32'(m0_err_o), 32'h0);
      check("wd_wait_stb", 32'(s_stb_o), 32'h1);
    end
`ifdef MEM_ARB_WATCHDOG_EN
    tick();
    #2;
    check("wd_exp_err", 32'(m0_err_o), 32'h1);
    check("wd_exp_stb", 32'(s_stb_o), 32'h0);
    check("wd_exp_cyc", 32'(s_cyc_o), 32'h0);
    check("wd_exp_ack", 32'(m0_ack_o), 32'h0);
    tick();
    m0_stb_i = 1'b0;
    #2;
    check("wd_after_grant", 32'(grant_o), 32'h0);
    check("wd_after_err", 32'(m0_err_o), 32'h0);
    // Ack arriving on the expiry cycle takes precedence.
    tick();
    m0_stb_i = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      #2;
      check("wd2_wait_grant", 32'(grant_o), 32'h1);
    end
    tick();
    s_ack_i = 1'b1;
    #2;
    check("wd2_ack", 32'(m0_ack_o), 32'h1);
    check("wd2_err", 32'(m0_err_o), 32'h0);
    check("wd2_stb", 32'(s_stb_o), 32'h1);
    tick();
    m0_stb_i = 1'b0; s_ack_i = 1'b0;
    #2;
    check("wd2_idle", 32'(grant_o), 32'h0);
`else
    for (int k = 4; k <= 10; k++) begin
      tick();
      #2;
      check("nowd_grant", 32'(grant_o), 32'h1);
      check("nowd_err", 32'(m0_err_o), 32'h0);
      check("nowd_stb", 32'(s_stb_o), 32'h1);
    end
    tick();
    s_ack_i = 1'b1;
    #2;
    check("nowd_ack", 32'(m0_ack_o), 32'h1);
    tick();
    m0_stb_i = 1'b0; s_ack_i = 1'b0;
    #2;
    check("nowd_idle", 32'(grant_o), 32'h0);
`endif

    // ---------------- async reset in GNT1 ----------------
    reset_dut();
    tick();
    m0_stb_i = 1'b1;
    tick();
    s_ack_i = 1'b1;
    #2;
    check("ar_m0_ack", 32'(m0_ack_o), 32'h1);
    tick();
    m0_stb_i = 1'b0; s_ack_i = 1'b0; m1_stb_i = 1'b1; m1_adr_i = 32'h0000_0C00;
    tick();
    s_ack_i = 1'b1; s_dat_i = 32'hCAFE_F00D;
    #1;
    check("ar_pre_grant", 32'(grant_o), 32'h2);
    check("ar_pre_m1_ack", 32'(m1_ack_o), 32'h1);
    rst_n_i = 1'b0;
    #1;
    check("ar_grant", 32'(grant_o), 32'h0);
    check("ar_stb", 32'(s_stb_o), 32'h0);
    check("ar_cyc", 32'(s_cyc_o), 32'h0);
    check("ar_adr", s_adr_o, 32'h0);
    check("ar_m1_ack", 32'(m1_ack_o), 32'h0);
    check("ar_m1_dat", m1_dat_o, 32'h0);
    clear_inputs();
    repeat (2) @(posedge clk_i);
    #3 rst_n_i = 1'b1;
    tick();
    m0_stb_i = 1'b1; m1_stb_i = 1'b1;
    #2;
    check("ar_rel_idle", 32'(grant_o), 32'h0);
    tick();
    #2;
    check("ar_rel_tie", 32'(grant_o), 32'h1);
    clear_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
